// File: rtl/l1_dcache_2way.sv
// 2-way set-associative, write-back, write-allocate L1 data cache.
// Tag/valid/dirty/data live in register arrays with combinational read.
// One LRU bit per set; saturating hit/miss counters for performance analysis.
module l1_dcache_2way #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WSEL_W = $clog2(LINE_W / DATA_W);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BYTE_W = OFF_W - WSEL_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MISS     = 3'd1;
  localparam logic [2:0] S_WRITEBK  = 3'd2;
  localparam logic [2:0] S_READMISS = 3'd3;
  localparam logic [2:0] S_FILLDONE = 3'd4;

  // Storage arrays
  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [LINE_W-1:0] data_q  [SETS][2];

  // Control state
  logic [2:0]  state_q, state_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_write_q, mem_write_d;
  logic        victim_q, victim_d;
  logic        ign_ack_q, ign_ack_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Address fields and lookup
  logic [TAG_W-1:0]  p1_tag;
  logic [IDX_W-1:0]  p1_idx;
  logic [WSEL_W-1:0] p1_wsel;
  logic              req_c, hit0_c, hit1_c, hit_c, hit_way_c;
  logic              hit_evt_c, wr_hit_c, ack_c, fill_c, vict_c;
  logic [LINE_W-1:0] rd_line_c;

  assign p1_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p1_idx  = p1_addr_i[OFF_W +: IDX_W];
  assign p1_wsel = p1_addr_i[OFF_W-1 -: WSEL_W];

  // Byte-within-word address bits carry no meaning for a word cache
  generate
    if (BYTE_W > 0) begin : g_byte_bits
      logic unused_byte_c;
      assign unused_byte_c = ^p1_addr_i[BYTE_W-1:0];
    end
  endgenerate

  // Tag compare, hit classification and memory handshake qualifiers
  always_comb begin
    req_c     = p1_MemRead_i | p1_MemWrite_i;
    hit0_c    = valid_q[p1_idx][0] & (tag_q[p1_idx][0] == p1_tag);
    hit1_c    = valid_q[p1_idx][1] & (tag_q[p1_idx][1] == p1_tag);
    hit_c     = hit0_c | hit1_c;
    hit_way_c = ~hit0_c;
    hit_evt_c = (state_q == S_IDLE) & req_c & hit_c;
    wr_hit_c  = hit_evt_c & p1_MemWrite_i;
    ack_c     = mem_ack_i & ~ign_ack_q;
    fill_c    = (state_q == S_READMISS) & ack_c;
    if (!valid_q[p1_idx][0]) begin
      vict_c = 1'b0;
    end else if (!valid_q[p1_idx][1]) begin
      vict_c = 1'b1;
    end else begin
      vict_c = lru_q[p1_idx];
    end
  end

  // CPU-side read data and stall
  always_comb begin
    rd_line_c  = data_q[p1_idx][hit1_c & ~hit0_c];
    p1_data_o  = rd_line_c[DATA_W*32'(p1_wsel) +: DATA_W];
    p1_stall_o = req_c & ~((state_q == S_IDLE) & hit_c);
  end

  // Memory-side address/data: victim line while writing back, else the CPU line
  always_comb begin
    mem_data_o = data_q[p1_idx][victim_q];
    mem_addr_o = {p1_tag, p1_idx, OFF_W'(0)};
    if (state_q == S_WRITEBK) begin
      mem_addr_o = {tag_q[p1_idx][victim_q], p1_idx, OFF_W'(0)};
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  // Next-state logic for the miss-handling FSM and counters
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    victim_d     = victim_q;
    ign_ack_d    = ign_ack_q & ~mem_ack_i;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            state_d = S_MISS;
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end
      S_MISS: begin
        victim_d     = vict_c;
        mem_enable_d = 1'b1;
        if (valid_q[p1_idx][vict_c] & dirty_q[p1_idx][vict_c]) begin
          state_d     = S_WRITEBK;
          mem_write_d = 1'b1;
        end else begin
          state_d     = S_READMISS;
          mem_write_d = 1'b0;
        end
      end
      S_WRITEBK: begin
        if (ack_c) begin
          state_d     = S_READMISS;
          mem_write_d = 1'b0;
        end
      end
      S_READMISS: begin
        if (ack_c) begin
          state_d      = S_FILLDONE;
          mem_enable_d = 1'b0;
        end
      end
      S_FILLDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  // FSM and counter registers; an aborted request arms the ack filter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      victim_q     <= 1'b0;
      ign_ack_q    <= mem_enable_q;
      hit_cnt_q    <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      victim_q     <= victim_d;
      ign_ack_q    <= ign_ack_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Valid/dirty/LRU bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q <= '0;
    end else begin
      if (fill_c) begin
        valid_q[p1_idx][victim_q] <= 1'b1;
        dirty_q[p1_idx][victim_q] <= 1'b0;
      end
      if (hit_evt_c) lru_q[p1_idx] <= ~hit_way_c;
      if (wr_hit_c) dirty_q[p1_idx][hit_way_c] <= 1'b1;
    end
  end

  // Tag and data arrays: line fill or single-word store
  always_ff @(posedge clk_i) begin
    if (rst_i && fill_c) begin
      tag_q[p1_idx][victim_q]  <= p1_tag;
      data_q[p1_idx][victim_q] <= mem_data_i;
    end else if (rst_i && wr_hit_c) begin
      data_q[p1_idx][hit_way_c][DATA_W*32'(p1_wsel) +: DATA_W] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_l1_dcache_2way.sv
// Directed self-checking bench for l1_dcache_2way with a simple line memory.
module tb_l1_dcache_2way;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned SETS   = 32;

  logic              clk, rst_i;
  logic [LINE_W-1:0] mem_data_i, mem_data_o;
  logic              mem_ack_i, mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] p1_data_i, p1_data_o;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic [31:0]       hit_cnt_o, miss_cnt_o;

  l1_dcache_2way #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .SETS(SETS)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model controls and transaction log
  int                ack_delay = 3;
  int                pulse_req = 0;
  logic              ev_wr   [$];
  logic [31:0]       ev_addr [$];
  logic [LINE_W-1:0] ev_data [$];
  logic [LINE_W-1:0] mem_store [logic [31:0]];

  int en_cycles;
  int addr_moved;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(w) + 32'hA000_0000;
    return l;
  endfunction

  function automatic logic [31:0] ev_a(input int i);
    if (i < ev_addr.size()) return ev_addr[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [1:0] ev_w(input int i);
    if (i < ev_wr.size()) return {1'b0, ev_wr[i]};
    return 2'b11;
  endfunction

  function automatic logic [LINE_W-1:0] ev_d(input int i);
    if (i < ev_data.size()) return ev_data[i];
    return '1;
  endfunction

  // Line memory: acks ack_delay cycles after enable, or pulses once on request
  initial begin : mem_model
    int wait_cnt;
    int pulse_done;
    wait_cnt   = 0;
    pulse_done = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (pulse_done != pulse_req) begin
        pulse_done++;
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
      end else if (mem_enable_o) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          wait_cnt  = 0;
          mem_ack_i = 1'b1;
          ev_wr.push_back(mem_write_o);
          ev_addr.push_back(mem_addr_o);
          ev_data.push_back(mem_data_o);
          if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
          else if (mem_store.exists(mem_addr_o)) mem_data_i = mem_store[mem_addr_o];
          else mem_data_i = mem_line(mem_addr_o);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  // One CPU access started at a negedge; returns load data and stalled cycles
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int stalls);
    logic        prev_en, prev_wr;
    logic [31:0] prev_addr;
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    stalls = 0; en_cycles = 0; addr_moved = 0;
    prev_en = 1'b0; prev_wr = 1'b0; prev_addr = '0;
    #1;
    while (p1_stall_o && stalls < 500) begin
      stalls++;
      if (mem_enable_o) begin
        en_cycles++;
        if (prev_en && prev_wr == mem_write_o && prev_addr != mem_addr_o) addr_moved++;
      end
      prev_en = mem_enable_o; prev_wr = mem_write_o; prev_addr = mem_addr_o;
      @(negedge clk);
      #1;
    end
    if (stalls >= 500) check("stall_timeout", 256'(p1_stall_o), 256'(0));
    rdata = p1_data_o;
    @(posedge clk);
    #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [31:0] rd;
    int          st, base, n;
    rst_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    do_reset();
    #1;
    check("rst_enable", 256'(mem_enable_o), 256'(0));
    check("rst_write",  256'(mem_write_o),  256'(0));
    check("rst_stall",  256'(p1_stall_o),   256'(0));
    check("rst_hits",   256'(hit_cnt_o),    256'(0));
    check("rst_misses", 256'(miss_cnt_o),   256'(0));
    @(negedge clk);

    // Cold load miss then hit on another word of the same line
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h40, 32'h0, rd, st);
    check("t1_stalls", 256'(st), 256'(6));
    check("t1_nev", 256'(ev_addr.size() - base), 256'(1));
    check("t1_rd_addr", 256'(ev_a(base)), 256'(32'h40));
    check("t1_rd_kind", 256'(ev_w(base)), 256'(0));
    check("t1_data", 256'(rd), 256'(32'hA000_0040));
    check("t1_misses", 256'(miss_cnt_o), 256'(1));
    check("t1_hits", 256'(hit_cnt_o), 256'(1));
    access(1'b1, 1'b0, 32'h48, 32'h0, rd, st);
    check("t1_w2_stalls", 256'(st), 256'(0));
    check("t1_w2_data", 256'(rd), 256'(32'hA000_0042));
    check("t1_w2_hits", 256'(hit_cnt_o), 256'(2));

    // Two lines sharing set 0, then re-loads that must hit
    do_reset();
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h000, 32'h0, rd, st);
    check("t2_a_stalls", 256'(st), 256'(6));
    access(1'b1, 1'b0, 32'h400, 32'h0, rd, st);
    check("t2_b_stalls", 256'(st), 256'(6));
    check("t2_b_data", 256'(rd), 256'(32'hA000_0400));
    access(1'b1, 1'b0, 32'h004, 32'h0, rd, st);
    check("t2_ra_stalls", 256'(st + en_cycles), 256'(0));
    check("t2_ra_data", 256'(rd), 256'(32'hA000_0001));
    access(1'b1, 1'b0, 32'h400, 32'h0, rd, st);
    check("t2_rb_stalls", 256'(st + en_cycles), 256'(0));
    check("t2_rb_data", 256'(rd), 256'(32'hA000_0400));
    check("t2_nev", 256'(ev_addr.size() - base), 256'(2));
    check("t2_hits", 256'(hit_cnt_o), 256'(4));
    check("t2_misses", 256'(miss_cnt_o), 256'(2));

    // Dirty line eviction through LRU order in set 0
    do_reset();
    access(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, rd, st);
    check("t3_st_stalls", 256'(st), 256'(6));
    access(1'b1, 1'b0, 32'h000, 32'h0, rd, st);
    access(1'b1, 1'b0, 32'h400, 32'h0, rd, st);
    check("t3_ld400_stalls", 256'(st), 256'(0));
    check("t3_ld400_data", 256'(rd), 256'(32'hDEAD_BEEF));
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h800, 32'h0, rd, st);
    check("t3_800_stalls", 256'(st), 256'(6));
    check("t3_800_nev", 256'(ev_addr.size() - base), 256'(1));
    check("t3_800_addr", 256'(ev_a(base)), 256'(32'h800));
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'hC00, 32'h0, rd, st);
    n = ev_addr.size() - base;
    check("t3_c00_stalls", 256'(st), 256'(9));
    check("t3_c00_nev", 256'(n), 256'(2));
    check("t3_wb_kind", 256'(ev_w(base)), 256'(1));
    check("t3_wb_addr", 256'(ev_a(base)), 256'(32'h400));
    check("t3_wb_line", ev_d(base), {mem_line(32'h400)[LINE_W-1:32], 32'hDEAD_BEEF});
    check("t3_rd_kind", 256'(ev_w(base + 1)), 256'(0));
    check("t3_rd_addr", 256'(ev_a(base + 1)), 256'(32'hC00));
    check("t3_c00_data", 256'(rd), 256'(32'hA000_0C00));
    check("t3_hits", 256'(hit_cnt_o), 256'(5));
    check("t3_misses", 256'(miss_cnt_o), 256'(4));

    // Load and store together on a hit: store wins and marks the line dirty
    access(1'b1, 1'b1, 32'h808, 32'h1234_5678, rd, st);
    check("t6_both_stalls", 256'(st), 256'(0));
    access(1'b1, 1'b0, 32'h808, 32'h0, rd, st);
    check("t6_readback", 256'(rd), 256'(32'h1234_5678));
    access(1'b1, 1'b0, 32'h000, 32'h0, rd, st);
    check("t6_clean_evict_stalls", 256'(st), 256'(6));
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h400, 32'h0, rd, st);
    check("t6_dirty_evict_stalls", 256'(st), 256'(9));
    check("t6_wb_addr", 256'(ev_a(base)), 256'(32'h800));
    check("t6_wb_word2", 256'(ev_d(base)[95:64]), 256'(32'h1234_5678));
    check("t6_wb_word0", 256'(ev_d(base)[31:0]), 256'(32'hA000_0800));
    check("t6_refetch_data", 256'(rd), 256'(32'hDEAD_BEEF));

    // Slow memory: request held stable for 20 cycles, one fill
    do_reset();
    ack_delay = 20;
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h1000, 32'h0, rd, st);
    ack_delay = 3;
    check("t4_stalls", 256'(st), 256'(23));
    check("t4_en_cycles", 256'(en_cycles), 256'(20));
    check("t4_addr_moved", 256'(addr_moved), 256'(0));
    check("t4_nev", 256'(ev_addr.size() - base), 256'(1));
    check("t4_data", 256'(rd), 256'(32'hA000_1000));

    // Reset during write-back drops the request and ignores the late ack
    do_reset();
    access(1'b0, 1'b1, 32'h40, 32'hCAFE_0001, rd, st);
    access(1'b1, 1'b0, 32'h440, 32'h0, rd, st);
    ack_delay = 1000;
    p1_addr_i = 32'h840; p1_MemRead_i = 1'b1;
    #1;
    n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("t5_wb_seen", 256'(mem_write_o), 256'(1));
    check("t5_wb_addr", 256'(mem_addr_o), 256'(32'h40));
    check("t5_wb_word0", 256'(mem_data_o[31:0]), 256'(32'hCAFE_0001));
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    check("t5_enable_dropped", 256'(mem_enable_o), 256'(0));
    check("t5_write_dropped", 256'(mem_write_o), 256'(0));
    pulse_req++;
    ack_delay = 3;
    repeat (3) @(negedge clk);
    #1;
    check("t5_enable_after_late_ack", 256'(mem_enable_o), 256'(0));
    check("t5_misses_after_reset", 256'(miss_cnt_o), 256'(0));
    @(negedge clk);
    base = ev_addr.size();
    access(1'b1, 1'b0, 32'h40, 32'h0, rd, st);
    check("t5_reload_stalls", 256'(st), 256'(6));
    check("t5_reload_addr", 256'(ev_a(base)), 256'(32'h40));
    check("t5_reload_data", 256'(rd), 256'(32'hA000_0040));
    check("t5_misses", 256'(miss_cnt_o), 256'(1));
    check("t5_hits", 256'(hit_cnt_o), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
